nstage_pipeline_register: RTL and testbench

- Parametrised successor to the three-stage pipeline register: a DEPTH-deep, WIDTH-bit shift-in / parallel-out register with its own controller.
- Collects DEPTH input words and presents them as one WIDTH*DEPTH-bit word on r0 when the consumer asserts ld.
- New versus the fixed 3x8 version:
  - configurable width and depth;
  - bubble-tolerant fill, which holds when en is low instead of free-running;
  - in_ready backpressure, r0_valid pulse and fill count outputs;
  - asynchronous reset.
- Sits between a byte-serial producer and a wide-word consumer.

---
 rtl/pipe_reg_pkg.sv | 14 +
 rtl/nstage_pipeline_register_if.sv | 30 +++
 rtl/pipe_shift_datapath.sv | 63 ++++++
 rtl/nstage_pipeline_register.sv | 112 +++++++++++
 tb/tb_nstage_pipeline_register.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the N-stage pipeline register: controller state
// encodings and the fill-counter width helper.
package pipe_reg_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_FILL = 2'b01;
    localparam logic [1:0] S_FULL = 2'b10;

    // Bits needed to count 0..depth held words.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nstage_pipeline_register_if.sv
// Producer/consumer bundle of the N-stage pipeline register. The master side
// is the producer+consumer pair; the slave side is the register itself.
interface nstage_pipeline_register_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    import pipe_reg_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic                     en;
    logic [WIDTH-1:0]         data;
    logic                     ld;
    logic                     in_ready;
    logic                     full;
    logic                     r0_valid;
    logic [WIDTH*DEPTH-1:0]   r0;
    logic [CNT_W-1:0]         fill_cnt;

    modport master (
        output en, data, ld,
        input  in_ready, full, r0_valid, r0, fill_cnt
    );

    modport slave (
        input  en, data, ld,
        output in_ready, full, r0_valid, r0, fill_cnt
    );

endinterface

// File: rtl/pipe_shift_datapath.sv
// Word storage for the N-stage pipeline register: DEPTH shift stages with
// the newest word entering at the top, plus the delivered-word register r0.
module pipe_shift_datapath #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift,
    input  logic                   clr,
    input  logic                   cap,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH*DEPTH-1:0] r0,
    output logic                   r0_valid
);

    logic [WIDTH-1:0]       p_reg  [DEPTH];
    logic [WIDTH-1:0]       p_next [DEPTH];
    logic [WIDTH*DEPTH-1:0] concat;
    logic [WIDTH*DEPTH-1:0] r0_reg;
    logic                   r0_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] src;
            // Top stage takes the incoming word, the others take their upper neighbour.
            if (gi == DEPTH - 1) begin : g_top
                assign src = data;
            end else begin : g_mid
                assign src = p_reg[gi+1];
            end
            // Shift wins over clear; the controller never asserts both.
            assign p_next[gi] = shift ? src : (clr ? '0 : p_reg[gi]);
            // Oldest word lands in the LSBs of the delivered word.
            assign concat[gi*WIDTH +: WIDTH] = p_reg[gi];
        end
    endgenerate

    // Stage registers, delivered word and its one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                p_reg[i] <= '0;
            end
            r0_reg       <= '0;
            r0_valid_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                p_reg[i] <= p_next[i];
            end
            // Capture uses the pre-edge stages, so a same-cycle shift is safe.
            if (cap) begin
                r0_reg <= concat;
            end
            r0_valid_reg <= cap;
        end
    end

    assign r0       = r0_reg;
    assign r0_valid = r0_valid_reg;

endmodule

// File: rtl/nstage_pipeline_register.sv
// N-stage shift-in / parallel-out pipeline register: controller FSM, fill
// counter and handshake; word storage lives in pipe_shift_datapath.
module nstage_pipeline_register
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    nstage_pipeline_register_if.slave       bus
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   shift;
    logic                   clr;
    logic                   cap;
    logic                   in_ready;
    logic [WIDTH*DEPTH-1:0] r0_w;
    logic                   r0_valid_w;

    // A full register can still take a word in the same cycle it is unloaded.
    assign in_ready = (state_reg != S_FULL) || bus.ld;

    // Next-state, next-count and datapath strobes.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift      = 1'b0;
        clr        = 1'b0;
        cap        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.en) begin
                    shift      = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = S_FILL;
                end else begin
                    clr        = 1'b1;
                    cnt_next   = '0;
                end
            end
            S_FILL: begin
                // Bubbles simply hold; ld has no effect until full.
                if (bus.en) begin
                    shift    = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(DEPTH - 1)) begin
                        state_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (bus.ld) begin
                    cap = 1'b1;
                    if (bus.en) begin
                        shift      = 1'b1;
                        cnt_next   = CNT_W'(1);
                        state_next = S_FILL;
                    end else begin
                        clr        = 1'b1;
                        cnt_next   = '0;
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                // Unused encoding: drop whatever is held and start over.
                clr        = 1'b1;
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Controller state and fill counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    pipe_shift_datapath #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .shift    (shift),
        .clr      (clr),
        .cap      (cap),
        .data     (bus.data),
        .r0       (r0_w),
        .r0_valid (r0_valid_w)
    );

    assign bus.in_ready = in_ready;
    assign bus.full     = (state_reg == S_FULL);
    assign bus.fill_cnt = cnt_reg;
    assign bus.r0       = r0_w;
    assign bus.r0_valid = r0_valid_w;

endmodule

// File: tb/tb_nstage_pipeline_register.sv
// Bench for nstage_pipeline_register: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model (8x3),
// and a directed run on a 4x5 instance.
module tb_nstage_pipeline_register;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nstage_pipeline_register_if #(.WIDTH(8), .DEPTH(3)) bus3 ();
    nstage_pipeline_register_if #(.WIDTH(4), .DEPTH(5)) bus5 ();

    nstage_pipeline_register #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    nstage_pipeline_register #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock edge on the 8x3 instance with the given inputs.
    task automatic cyc(input logic e, input logic [7:0] d, input logic l);
        bus3.en   = e;
        bus3.data = d;
        bus3.ld   = l;
        @(posedge clk);
        #1;
    endtask

    // One clock edge on the 4x5 instance with the given inputs.
    task automatic cyc5(input logic e, input logic [3:0] d, input logic l);
        bus5.en   = e;
        bus5.data = d;
        bus5.ld   = l;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the 8x3 instance: a queue of held words.
    logic [7:0]  mq[$];
    logic [23:0] m_r0;
    logic        m_valid;

    // Inputs change just after each rising edge, so at the falling edge they
    // are exactly what the next rising edge will sample.
    initial begin
        mq.delete();
        m_r0    = '0;
        m_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mq.delete();
                m_r0    = '0;
                m_valid = 1'b0;
            end
            check("fill_cnt", 32'(bus3.fill_cnt), 32'(mq.size()));
            check("full", 32'(bus3.full), 32'(mq.size() == 3));
            check("in_ready", 32'(bus3.in_ready), 32'((mq.size() != 3) || bus3.ld));
            check("r0", 32'(bus3.r0), 32'(m_r0));
            check("r0_valid", 32'(bus3.r0_valid), 32'(m_valid));
            if (bus3.r0_valid) begin
                $display("deliver r0=%06h at %0t", bus3.r0, $time);
            end
            if (rst) begin
                logic accept;
                accept  = bus3.en && ((mq.size() != 3) || bus3.ld);
                m_valid = 1'b0;
                if (mq.size() == 3 && bus3.ld) begin
                    m_r0 = '0;
                    for (int i = 0; i < 3; i++) begin
                        m_r0 = m_r0 | (24'(mq[i]) << (8 * i));
                    end
                    mq.delete();
                    m_valid = 1'b1;
                end
                if (accept) begin
                    mq.push_back(bus3.data);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus3.en = 1'b0; bus3.data = '0; bus3.ld = 1'b0;
        bus5.en = 1'b0; bus5.data = '0; bus5.ld = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_r0", 32'(bus3.r0), 32'h0);
        check("reset_fill", 32'(bus3.fill_cnt), 32'h0);
        check("reset_full", 32'(bus3.full), 32'h0);

        // Basic fill and delivery.
        cyc(1, 8'h11, 0); check("basic_cnt1", 32'(bus3.fill_cnt), 32'd1);
        cyc(1, 8'h22, 0); check("basic_cnt2", 32'(bus3.fill_cnt), 32'd2);
        cyc(1, 8'h33, 0); check("basic_cnt3", 32'(bus3.fill_cnt), 32'd3);
        bus3.en = 1'b0;
        #1;
        check("basic_full", 32'(bus3.full), 32'd1);
        check("basic_in_ready", 32'(bus3.in_ready), 32'd0);
        check("basic_r0_before", 32'(bus3.r0), 32'h0);
        cyc(0, 8'h00, 1);
        check("basic_r0", 32'(bus3.r0), 32'h332211);
        check("basic_valid", 32'(bus3.r0_valid), 32'd1);
        check("basic_cnt0", 32'(bus3.fill_cnt), 32'd0);
        cyc(0, 8'h00, 0);
        check("basic_valid_once", 32'(bus3.r0_valid), 32'd0);
        check("basic_r0_hold", 32'(bus3.r0), 32'h332211);

        // Bubble-tolerant fill.
        cyc(1, 8'hA1, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        check("bubble_cnt1", 32'(bus3.fill_cnt), 32'd1);
        cyc(1, 8'hA2, 0);
        cyc(0, 8'h00, 0);
        check("bubble_cnt2", 32'(bus3.fill_cnt), 32'd2);
        check("bubble_not_full", 32'(bus3.full), 32'd0);
        cyc(1, 8'hA3, 0);
        check("bubble_full", 32'(bus3.full), 32'd1);
        cyc(0, 8'h00, 1);
        check("bubble_r0", 32'(bus3.r0), 32'hA3A2A1);

        // Backpressure while full, then simultaneous ld+en.
        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        cyc(1, 8'h03, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'hFF, 0);
            check("bp_in_ready", 32'(bus3.in_ready), 32'd0);
            check("bp_cnt", 32'(bus3.fill_cnt), 32'd3);
        end
        cyc(1, 8'h04, 1);
        check("sim_r0", 32'(bus3.r0), 32'h030201);
        check("sim_cnt", 32'(bus3.fill_cnt), 32'd1);
        check("sim_full", 32'(bus3.full), 32'd0);
        cyc(1, 8'h05, 0);
        cyc(1, 8'h06, 0);
        cyc(0, 8'h00, 1);
        check("sim_r0_next", 32'(bus3.r0), 32'h060504);

        // Asynchronous reset mid-fill.
        cyc(1, 8'h77, 0);
        cyc(1, 8'h88, 0);
        bus3.en = 1'b0;
        check("mid_cnt2", 32'(bus3.fill_cnt), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_cnt", 32'(bus3.fill_cnt), 32'd0);
        check("arst_r0", 32'(bus3.r0), 32'h0);
        check("arst_full", 32'(bus3.full), 32'd0);
        check("arst_valid", 32'(bus3.r0_valid), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 8'h9A, 0);
        cyc(1, 8'h9B, 0);
        cyc(1, 8'h9C, 0);
        cyc(0, 8'h00, 1);
        check("arst_r0_new", 32'(bus3.r0), 32'h9C9B9A);
        cyc(0, 8'h00, 0);

        // Generic parameters on the 4x5 instance.
        for (int i = 1; i <= 5; i++) begin
            cyc5(1, 4'(i), 0);
        end
        bus5.en = 1'b0;
        check("g_full", 32'(bus5.full), 32'd1);
        check("g_cnt", 32'(bus5.fill_cnt), 32'd5);
        check("g_r0_before", 32'(bus5.r0), 32'h0);
        cyc5(0, 4'h0, 1);
        check("g_r0", 32'(bus5.r0), 32'h54321);
        check("g_valid", 32'(bus5.r0_valid), 32'd1);
        check("g_cnt0", 32'(bus5.fill_cnt), 32'd0);
        cyc5(0, 4'h0, 0);
        check("g_valid_once", 32'(bus5.r0_valid), 32'd0);

        // Randomized traffic on the 8x3 instance, checked by the model.
        for (int n = 0; n < 800; n++) begin
            cyc(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        cyc(0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
